// File: rtl/zero_scan_sequencer.sv
// Sequential leading-zero counter: scans a captured operand one segment per cycle,
// MSB segment first, using a single shared segment-wide zero detector.
module zero_scan_sequencer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SEG_WIDTH  = 8,
    localparam int unsigned CNT_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  abort_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [CNT_W-1:0]      lzc_o,
    output logic                  all_zero_o
);

    localparam int unsigned NSEG  = DATA_WIDTH / SEG_WIDTH;
    localparam int unsigned IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int unsigned SLZ_W = (SEG_WIDTH > 1) ? $clog2(SEG_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      lzc_q, lzc_d;
    logic                  all_zero_q, all_zero_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic [SEG_WIDTH-1:0]  seg;
    logic                  seg_zero;
    logic [SLZ_W-1:0]      seg_lz;
    logic                  last_seg;

    // Segment select mux feeding the one shared zero detector and priority encoder
    always_comb begin
        seg = '0;
        for (int s = 0; s < NSEG; s++) begin
            if (idx_q == IDX_W'(s)) begin
                seg = data_q[DATA_WIDTH-1-s*SEG_WIDTH -: SEG_WIDTH];
            end
        end
        seg_zero = (seg == '0);
        seg_lz   = '0;
        for (int b = 0; b < SEG_WIDTH; b++) begin
            if (seg[b]) begin
                seg_lz = SLZ_W'(SEG_WIDTH - 1 - b);
            end
        end
        last_seg = (idx_q == IDX_W'(NSEG - 1));
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort takes priority over scan completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (!seg_zero || last_seg) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        data_d     = data_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        lzc_d      = lzc_q;
        all_zero_d = all_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    data_d = data_i;
                    idx_d  = '0;
                    cnt_d  = '0;
                end
            end
            SCAN: begin
                if (!abort_i) begin
                    if (!seg_zero) begin
                        lzc_d      = cnt_q + CNT_W'(seg_lz);
                        all_zero_d = 1'b0;
                    end else if (last_seg) begin
                        lzc_d      = CNT_W'(DATA_WIDTH);
                        all_zero_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(SEG_WIDTH);
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            lzc_q       <= '0;
            all_zero_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            lzc_q       <= lzc_d;
            all_zero_q  <= all_zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign lzc_o       = lzc_q;
    assign all_zero_o  = all_zero_q;

endmodule
